uci_response_encoder: RTL

- Converts engine results into UCI text and streams ASCII bytes, one at a time, to the UART transmitter.
- Produces two line types:
  - `bestmove <move>\n`, built from a best move (from/to squares plus promotion).
  - `info depth D score cp S nodes N\n`, built from search info.
- Sits between the engine coordinator / uci_handler and uart_transmit. It is the response side that pairs with the UCI command decoder.

---
 rtl/uci_response_encoder.sv | 347 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uci_response_encoder.sv
// UCI response encoder: turns best-move and search-info records into ASCII lines for the UART.
// Define UCI_INFO_EN to build the info-line path (decimal converter and info strings).
module uci_response_encoder #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [5:0]  move_from_in,
  input  logic [5:0]  move_to_in,
  input  logic [2:0]  move_promo_in,
  input  logic        move_valid_in,
  output logic        move_ready_out,
  input  logic [7:0]  info_depth_in,
  input  logic [15:0] info_score_in,
  input  logic [31:0] info_nodes_in,
  input  logic        info_valid_in,
  output logic        info_ready_out,
  output logic [7:0]  char_out,
  output logic        char_out_valid,
  input  logic        char_out_ready,
  output logic        busy_out
);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, EMIT_STR, EMIT_NUM, EMIT_MOVE, EMIT_EOL} state_t;
  typedef enum logic [2:0] {
    SEG_BM, SEG_DEPTH_S, SEG_DEPTH_N, SEG_SCORE_S, SEG_SCORE_N, SEG_NODES_S, SEG_NODES_N
  } seg_t;

  localparam logic [8*9-1:0]  S_BESTMOVE = "bestmove ";
`ifdef UCI_INFO_EN
  localparam logic [8*11-1:0] S_DEPTH    = "info depth ";
  localparam logic [8*10-1:0] S_SCORE    = " score cp ";
  localparam logic [8*7-1:0]  S_NODES    = " nodes ";
`endif

  state_t        state_q, state_d;
  seg_t          seg_q, seg_d;
  logic [3:0]    idx_q;
  logic          idx_clr, idx_inc;
  logic [GW-1:0] gap_q;
  logic          busy_q;
  logic          byte_vld;
  logic [7:0]    byte_val;
  logic          xfer;
  logic          move_acc;
  logic [5:0]    from_p0, to_p0;
  logic [2:0]    promo_p0;
  logic          has_promo;

  function automatic logic [7:0] str_char(input seg_t seg, input logic [3:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (seg)
      SEG_BM:      c = S_BESTMOVE[8*(8-int'(idx)) +: 8];
`ifdef UCI_INFO_EN
      SEG_DEPTH_S: c = S_DEPTH[8*(10-int'(idx)) +: 8];
      SEG_SCORE_S: c = S_SCORE[8*(9-int'(idx)) +: 8];
      SEG_NODES_S: c = S_NODES[8*(6-int'(idx)) +: 8];
`endif
      default:     c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] str_last(input seg_t seg);
    logic [3:0] n;
    case (seg)
      SEG_DEPTH_S: n = 4'd10;
      SEG_SCORE_S: n = 4'd9;
      SEG_NODES_S: n = 4'd6;
      default:     n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] promo_char(input logic [2:0] p);
    logic [7:0] c;
    case (p)
      3'd1:    c = 8'h6E;
      3'd2:    c = 8'h62;
      3'd3:    c = 8'h72;
      3'd4:    c = 8'h71;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] move_char(input logic [3:0] idx, input logic [5:0] f,
                                           input logic [5:0] t, input logic [2:0] p);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'h61 + {5'd0, f[2:0]};
      4'd1:    c = 8'h31 + {5'd0, f[5:3]};
      4'd2:    c = 8'h61 + {5'd0, t[2:0]};
      4'd3:    c = 8'h31 + {5'd0, t[5:3]};
      default: c = promo_char(p);
    endcase
    return c;
  endfunction

  assign has_promo = (promo_p0 >= 3'd1) && (promo_p0 <= 3'd4);

`ifdef UCI_INFO_EN
  logic               info_acc;
  logic [7:0]         depth_p0;
  logic signed [15:0] score_p0;
  logic [31:0]        nodes_p0;
  logic [31:0]        num_q;
  logic [3:0]         pow_q;   // 0 selects 10^9 ... 9 selects 10^0
  logic [3:0]         dig_q;
  logic               lead_q;  // a significant digit has already gone out
  logic               neg_q;
  logic               num_ge, show;
  logic               num_load, sub_en, pow_adv, lead_set, neg_clr;

  function automatic logic [31:0] pow10(input logic [3:0] p);
    logic [31:0] v;
    case (p)
      4'd0:    v = 32'd1000000000;
      4'd1:    v = 32'd100000000;
      4'd2:    v = 32'd10000000;
      4'd3:    v = 32'd1000000;
      4'd4:    v = 32'd100000;
      4'd5:    v = 32'd10000;
      4'd6:    v = 32'd1000;
      4'd7:    v = 32'd100;
      4'd8:    v = 32'd10;
      default: v = 32'd1;
    endcase
    return v;
  endfunction

  // 17-bit magnitude so that -32768 maps to +32768 without wrapping
  function automatic logic [16:0] score_mag(input logic signed [15:0] s);
    logic signed [16:0] w;
    w = {s[15], s};
    if (w < 0) w = -w;
    return w;
  endfunction

  assign info_ready_out = (state_q == IDLE) && !rst_in;
  assign move_ready_out = (state_q == IDLE) && !rst_in && !info_valid_in;
  assign info_acc       = info_valid_in && info_ready_out;
  assign num_ge         = (num_q >= pow10(pow_q));
  assign show           = (dig_q != 4'd0) || lead_q || (pow_q == 4'd9);
`else
  logic unused_info;
  assign unused_info    = ^{info_depth_in, info_score_in, info_nodes_in, info_valid_in};
  assign info_ready_out = 1'b1;
  assign move_ready_out = (state_q == IDLE) && !rst_in;
`endif

  assign move_acc       = move_valid_in && move_ready_out;
  assign char_out_valid = byte_vld && (gap_q == '0) && char_out_ready && !rst_in;
  assign char_out       = char_out_valid ? byte_val : 8'h00;
  assign xfer           = char_out_valid;
  assign busy_out       = busy_q;

  always_comb begin
    byte_vld = 1'b0;
    byte_val = 8'h00;
    case (state_q)
      EMIT_STR: begin
        byte_vld = 1'b1;
        byte_val = str_char(seg_q, idx_q);
      end
      EMIT_MOVE: begin
        byte_vld = 1'b1;
        byte_val = move_char(idx_q, from_p0, to_p0, promo_p0);
      end
`ifdef UCI_INFO_EN
      EMIT_NUM: begin
        if (neg_q) begin
          byte_vld = 1'b1;
          byte_val = 8'h2D;
        end else if (!num_ge && show) begin
          byte_vld = 1'b1;
          byte_val = 8'h30 + {4'h0, dig_q};
        end
      end
`endif
      EMIT_EOL: begin
        byte_vld = 1'b1;
        byte_val = 8'h0A;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
`ifdef UCI_INFO_EN
    num_load = 1'b0;
    sub_en   = 1'b0;
    pow_adv  = 1'b0;
    lead_set = 1'b0;
    neg_clr  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        idx_clr = 1'b1;
`ifdef UCI_INFO_EN
        if (info_acc) begin
          state_d = EMIT_STR;
          seg_d   = SEG_DEPTH_S;
        end else
`endif
        if (move_acc) begin
          state_d = EMIT_STR;
          seg_d   = SEG_BM;
        end
      end
      EMIT_STR: begin
        if (xfer) begin
          if (idx_q == str_last(seg_q)) begin
            idx_clr = 1'b1;
`ifdef UCI_INFO_EN
            if (seg_q == SEG_BM) begin
              state_d = EMIT_MOVE;
            end else begin
              state_d  = EMIT_NUM;
              seg_d    = seg_t'(seg_q + 3'd1);
              num_load = 1'b1;
            end
`else
            state_d = EMIT_MOVE;
`endif
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      EMIT_MOVE: begin
        if (xfer) begin
          if (idx_q == 4'd4 || (idx_q == 4'd3 && !has_promo)) state_d = EMIT_EOL;
          else idx_inc = 1'b1;
        end
      end
`ifdef UCI_INFO_EN
      EMIT_NUM: begin
        if (neg_q) begin
          if (xfer) neg_clr = 1'b1;
        end else if (num_ge) begin
          sub_en = 1'b1;
        end else if (show) begin
          if (xfer) begin
            lead_set = 1'b1;
            if (pow_q == 4'd9) begin
              if (seg_q == SEG_NODES_N) begin
                state_d = EMIT_EOL;
              end else begin
                state_d = EMIT_STR;
                seg_d   = seg_t'(seg_q + 3'd1);
                idx_clr = 1'b1;
              end
            end else begin
              pow_adv = 1'b1;
            end
          end
        end else begin
          pow_adv = 1'b1;
        end
      end
`endif
      EMIT_EOL: begin
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      seg_q   <= SEG_BM;
      idx_q   <= 4'd0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      busy_q  <= (state_d != IDLE);
      if (idx_clr)      idx_q <= 4'd0;
      else if (idx_inc) idx_q <= idx_q + 4'd1;
      if (xfer)                gap_q <= GAP_LOAD;
      else if (gap_q != '0)    gap_q <= gap_q - GW'(1);
    end
  end

  // Capture stage: record fields on the accept cycle
  always_ff @(posedge clk_in) begin
    if (move_acc) begin
      from_p0  <= move_from_in;
      to_p0    <= move_to_in;
      promo_p0 <= move_promo_in;
    end
`ifdef UCI_INFO_EN
    if (info_acc) begin
      depth_p0 <= info_depth_in;
      score_p0 <= info_score_in;
      nodes_p0 <= info_nodes_in;
    end
`endif
  end

`ifdef UCI_INFO_EN
  // Decimal stage: one subtraction of the current power of ten per cycle
  always_ff @(posedge clk_in) begin
    if (num_load) begin
      pow_q  <= 4'd0;
      dig_q  <= 4'd0;
      lead_q <= 1'b0;
      case (seg_d)
        SEG_DEPTH_N: begin
          num_q <= {24'd0, depth_p0};
          neg_q <= 1'b0;
        end
        SEG_SCORE_N: begin
          num_q <= {15'd0, score_mag(score_p0)};
          neg_q <= score_p0[15];
        end
        default: begin
          num_q <= nodes_p0;
          neg_q <= 1'b0;
        end
      endcase
    end else begin
      if (neg_clr) neg_q <= 1'b0;
      if (sub_en) begin
        num_q <= num_q - pow10(pow_q);
        dig_q <= dig_q + 4'd1;
      end
      if (pow_adv) begin
        pow_q <= pow_q + 4'd1;
        dig_q <= 4'd0;
      end
      if (lead_set) lead_q <= 1'b1;
    end
  end
`endif

endmodule
